// File: rtl/c1_mux_arbiter.sv
// c1_mux_arbiter: round-robin arbiter and sequencer sharing one C1 four-input select-mux among A0/A1/B0/B1
//   clk, rst            clock, synchronous active-high reset
//   req[3:0]            requests (bit0=A0, bit1=A1, bit2=B0, bit3=B1)
//   A0, A1, B0, B1      requester data, size bits each
//   ack[3:0]            one-hot pulse, beat from requester i accepted this cycle
//   SA, SB, S0, S1      select lines for the shared C1 path
//   out_data/out_valid  registered muxed beat, out_ready accepts it
//   grant_id, busy      current grantee, FSM in GRANT
//   C1_ARB_BURST_EN     when defined, a grant also releases after BURST_LEN accepted beats
module c1_mux_arbiter #(
    parameter int size      = 5,
    parameter int BURST_LEN = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      req,
    input  logic [size-1:0] A0,
    input  logic [size-1:0] A1,
    input  logic [size-1:0] B0,
    input  logic [size-1:0] B1,
    input  logic            out_ready,
    output logic [3:0]      ack,
    output logic            SA,
    output logic            SB,
    output logic            S0,
    output logic            S1,
    output logic [size-1:0] out_data,
    output logic            out_valid,
    output logic [1:0]      grant_id,
    output logic            busy
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t state;
    logic [1:0] rr_ptr;
    logic [1:0] pick;
    logic [size-1:0] mux_data;
    logic slot_free;
    logic accept;
    logic last_beat;
    logic rel;
`ifdef C1_ARB_BURST_EN
    localparam int CW = $clog2(BURST_LEN + 1);
    logic [CW-1:0] beat_cnt;
    assign last_beat = beat_cnt == CW'(BURST_LEN - 1);
`else
    assign last_beat = 1'b0;
`endif
    assign busy      = state == GRANT;
    assign SA        = busy & (grant_id == 2'd1);
    assign SB        = busy & (grant_id == 2'd3);
    assign S0        = busy & grant_id[1];
    assign S1        = 1'b0;
    assign mux_data  = (S0 | S1) ? (SB ? B1 : B0) : (SA ? A1 : A0);
    assign slot_free = !out_valid | out_ready;
    // rst gate keeps the reset cycle ack-free even mid-burst
    assign accept    = busy & req[grant_id] & slot_free & !rst;
    assign ack       = accept ? 4'b0001 << grant_id : 4'b0000;
    assign rel       = busy & (!req[grant_id] | (accept & last_beat));
    // scan from the highest offset down so the nearest request at/after rr_ptr wins
    always_comb begin
        pick = rr_ptr;
        for (int i = 3; i >= 0; i--)
            if (req[rr_ptr + 2'(i)]) pick = rr_ptr + 2'(i);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= 2'd0;
            grant_id  <= 2'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
`ifdef C1_ARB_BURST_EN
            beat_cnt  <= '0;
`endif
        end else begin
            if (accept) begin
                out_data  <= mux_data;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (state == IDLE) begin
                if (|req) begin
                    grant_id <= pick;
                    state    <= GRANT;
`ifdef C1_ARB_BURST_EN
                    beat_cnt <= '0;
`endif
                end
            end else begin
`ifdef C1_ARB_BURST_EN
                if (accept) beat_cnt <= beat_cnt + 1'b1;
`endif
                if (rel) begin
                    state  <= IDLE;
                    rr_ptr <= grant_id + 2'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_c1_mux_arbiter.sv
// tb_c1_mux_arbiter: directed self-checking bench for c1_mux_arbiter (BURST_LEN=2)
module tb_c1_mux_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'hF;
    logic [4:0] a0 = 5'h01, a1 = 5'h0A, b0 = 5'h13, b1 = 5'h15;
    logic       out_ready = 1'b1;
    logic [3:0] ack;
    logic       sa, sb, s0, s1;
    logic [4:0] out_data;
    logic       out_valid;
    logic [1:0] grant_id;
    logic       busy;
    int n_checks = 0;
    int n_errors = 0;
    c1_mux_arbiter #(.size(5), .BURST_LEN(2)) dut (
        .clk(clk), .rst(rst), .req(req),
        .A0(a0), .A1(a1), .B0(b0), .B1(b1),
        .out_ready(out_ready), .ack(ack),
        .SA(sa), .SB(sb), .S0(s0), .S1(s1),
        .out_data(out_data), .out_valid(out_valid),
        .grant_id(grant_id), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic next;
        @(posedge clk);
        #1;
    endtask
    initial begin
        logic [4:0] dat [4];
        dat = '{5'h01, 5'h0A, 5'h13, 5'h15};
        next;
        check("rst_busy", busy, 0);
        check("rst_ack", ack, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_sel", {sa, sb, s0, s1}, 0);
        check("rst_gid", grant_id, 0);
        next;
        check("rst2_ack", ack, 0);
        check("rst2_busy", busy, 0);
        rst = 1'b0;
        #1;
        check("idle_ack", ack, 0);
        check("idle_busy", busy, 0);
        next;
        check("first_busy", busy, 1);
        check("first_gid", grant_id, 0);
        check("first_sel", {sa, sb, s0, s1}, 0);
        check("first_ack", ack, 4'b0001);
`ifdef C1_ARB_BURST_EN
        for (int k = 0; k < 5; k++) begin
            check("rr_gid", grant_id, k % 4);
            check("rr_ack1", ack, 1 << (k % 4));
            next;
            check("rr_ack2", ack, 1 << (k % 4));
            check("rr_data", out_data, dat[k % 4]);
            next;
            check("rr_gap_ack", ack, 0);
            check("rr_gap_busy", busy, 0);
            next;
        end
`else
        for (int i = 2; i <= 10; i++) begin
            next;
            check("hold_ack", ack, 4'b0001);
            check("hold_data", out_data, a0);
            check("hold_valid", out_valid, 1);
        end
        next;
        req = 4'b0010;
        #1;
        check("drop_ack", ack, 0);
        check("drop_busy", busy, 1);
        next;
        check("drop_idle", busy, 0);
        check("drop_idle_ack", ack, 0);
        check("drop_drain", out_valid, 0);
        next;
        check("a1_gid", grant_id, 1);
        check("a1_sel", {sa, sb, s0, s1}, 4'b1000);
        check("a1_ack", ack, 4'b0010);
`endif
        rst = 1'b1;
        #1;
        check("midrst_ack", ack, 0);
        next;
        check("midrst_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        rst = 1'b0;
        req = 4'b1000;
        #1;
        next;
        check("b1_gid", grant_id, 3);
        check("b1_sel", {sa, sb, s0, s1}, 4'b0110);
        check("b1_ack", ack, 4'b1000);
        next;
        check("b1_ack2", ack, 4'b1000);
        check("b1_data", out_data, 5'h15);
        check("b1_valid", out_valid, 1);
        next;
        req = 4'b0000;
        #1;
        check("b1_end_ack", ack, 0);
        check("b1_end_data", out_data, 5'h15);
        next;
        check("b1_end_busy", busy, 0);
        check("b1_end_drain", out_valid, 0);
        req = 4'b0010;
        #1;
        next;
        check("bp_gid", grant_id, 1);
        check("bp_ack1", ack, 4'b0010);
        next;
        a1 = 5'h0B;
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) next;
            check("bp_stall_ack", ack, 0);
            check("bp_stall_data", out_data, 5'h0A);
            check("bp_stall_valid", out_valid, 1);
        end
        next;
        out_ready = 1'b1;
        #1;
        check("bp_resume_ack", ack, 4'b0010);
        next;
        req = 4'b0000;
        #1;
        check("bp_end_ack", ack, 0);
        check("bp_end_data", out_data, 5'h0B);
        check("bp_end_valid", out_valid, 1);
        next;
        check("bp_end_busy", busy, 0);
        req = 4'b1100;
        b1 = 5'h07;
        #1;
        next;
        check("er_gid", grant_id, 2);
        check("er_sel", {sa, sb, s0, s1}, 4'b0010);
        check("er_ack", ack, 4'b0100);
        next;
        req = 4'b1001;
        #1;
        check("er_drop_ack", ack, 0);
        check("er_drop_busy", busy, 1);
        check("er_drop_data", out_data, 5'h13);
        next;
        check("er_idle", busy, 0);
        check("er_idle_ack", ack, 0);
        next;
        check("er_next_gid", grant_id, 3);
        check("er_next_ack", ack, 4'b1000);
        next;
        check("er_next_data", out_data, 5'h07);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/c1_mux_arbiter.md
# c1_mux_arbiter

Round-robin arbiter and sequencer that shares one C1 four-input select-mux datapath among four requesters: A0, A1, B0 and B1. It computes the SA/SB/S0/S1 select lines and holds a grant for a burst of beats. It moves each selected beat into a registered output stage with a valid/ready handshake, and acknowledges each requester per accepted beat. It sits between the requesting units and the downstream consumer of the muxed bus.

## Interface
- `size`, 5, data width of each requester bus and of `out_data`.
- `BURST_LEN`, 4, maximum beats per grant (≥1); used only with `C1_ARB_BURST_EN`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, **synchronous, active-high**.
- `req`  in  4  request; bit0=A0, bit1=A1, bit2=B0, bit3=B1.
- `A0`, `A1`, `B0`, `B1`  in  size each  requester data.
- `ack`  out  4  one-hot pulse; the beat from requester i was accepted this cycle.
- `SA`, `SB`, `S0`, `S1`  out  1 each  select lines for the shared C1 path.
- `out_data`  out  size  registered muxed beat.
- `out_valid`  out  1  `out_data` holds an unconsumed beat.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.
- `grant_id`  out  2  current grantee; valid while `busy`=1.
- `busy`  out  1  FSM is in GRANT.

## Operation
- **Select encoding**, driven from the registered `grant_id`:
  - 0 (A0): SA=0, S0=0.
  - 1 (A1): SA=1, S0=0.
  - 2 (B0): SB=0, S0=1.
  - 3 (B1): SB=1, S0=1.
  - S1 is constant 0. Unused selects are 0.
  - In IDLE, all selects are 0.
- **Internal mux:** the block contains the equivalent mux (`S0|S1` chooses the B pair over the A pair). `mux_data` is the selected input.
- **FSM states: IDLE and GRANT.**
- **IDLE:**
  - If `req`≠0, pick the first set bit at or after `rr_ptr`, wrapping 3→0.
  - Register the result in `grant_id`, clear `beat_cnt`, go to GRANT.
  - If `req`=0, stay in IDLE.
- **Output slot free:** `slot_free` = !`out_valid` | `out_ready`.
- **GRANT, beat accept:** when `req[grant_id]` & `slot_free`, the beat is accepted:
  - `ack[grant_id]`=1.
  - `out_data`←`mux_data`, `out_valid`←1.
  - `beat_cnt`++.
- **Output drain:** if `out_valid` & `out_ready` and no beat is accepted this cycle, `out_valid`←0.
- **Release** (GRANT→IDLE, `rr_ptr`←`grant_id`+1 mod 4), on either condition:
  - `req[grant_id]`=0 in GRANT. No ack is issued that cycle.
  - The burst limit is reached; see Configuration.
- **Unaffected by release:** the output register is not touched by release; a pending beat remains until consumed.
- **Mid-grant requests:** requests from other sources are ignored until release. Their data is never sampled.
- **ack scope:** `ack` is only ever asserted in GRANT, at most one bit per cycle.
- **Reset:** FSM=IDLE, `rr_ptr`=0, `grant_id`=0, `beat_cnt`=0, `out_valid`=0, `out_data`=0, `ack`=0, `busy`=0. All selects are 0.
- **Reset mid-burst:** any pending beat is discarded. No ack is issued in the reset cycle.

## Timing
- **Arbitration latency:** `req` seen in IDLE at cycle t gives `busy`=1 and selects valid at t+1. The earliest `ack` is at t+1; `out_valid` rises at t+2.
- **Throughput:** 1 beat/cycle while `out_ready`=1 and `req[grant_id]` is held.
- **Back-pressure:** with `out_valid`=1 and `out_ready`=0, no ack is issued. `out_data` and `out_valid` hold stable until consumed.
- **Re-arbitration gap:** the release cycle plus one IDLE cycle, i.e. at least 1 cycle with no ack between grants.
- **Requester rule:** requesters must present data with `req` and hold both until `ack`. Dropping `req` without an ack is treated as end of burst.

## Configuration
- Macro: `C1_ARB_BURST_EN`.
- **Defined:** the grant also releases on the accept of beat number `BURST_LEN`, in the same cycle.
  - `beat_cnt` is $clog2(`BURST_LEN`+1) bits wide.
  - This prevents starvation from a held request.
- **Undefined:** release happens only when `req` drops.
  - `beat_cnt` is absent.
  - `BURST_LEN` is ignored.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `req`=4'hF. → All outputs 0 during reset. The first grant goes to A0 (`grant_id`=0, SA=0, S0=0) the cycle after `rst` falls.
- **Single requester:** `req`=4'b1000, B1=5'h15, `out_ready`=1. → S0=1, SB=1 from t+1; `ack`=4'b1000 each cycle; `out_data`=5'h15 with `out_valid`=1 from t+2.
- **Round robin:** all `req` held, `BURST_LEN`=2, `C1_ARB_BURST_EN` defined. → Grant order is 0,1,2,3,0, each grant with exactly 2 acks, separated by 1 idle cycle.
- **Back-pressure:** `out_ready`=0 for 3 cycles mid-burst on A1. → `ack` stays 0; `out_data`/`out_valid` stay frozen; on `out_ready`=1 transfer resumes with the next A1 beat.
- **Early release:** `req[2]` drops after 1 beat while `req[3]`=1. → B0 is released and `rr_ptr`=3; B1 is granted 2 cycles later.
- **Macro off:** A0 holds `req` for 10 cycles with `req[1]`=1 and `C1_ARB_BURST_EN` undefined. → A0 receives 10 consecutive acks; A1 is granted only after A0 drops `req`.
